// File: rtl/plot_sched_pkg.sv
// ---- plot_sched_pkg : shared types and constants for plot_scheduler, rev 1.0 ----
`default_nettype none

package plot_sched_pkg;

    localparam int X_W          = 8;
    localparam int Y_W          = 7;
    localparam int COL_W        = 3;
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam int DEF_SQ_SIZE  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SQUARE = 2'd1,
        CLEAR  = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int clamp_coord(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/plot_scheduler_if.sv
// ---- plot_scheduler_if : request/ack and pixel-write bundle, rev 1.0 ----
`default_nettype none

interface plot_scheduler_if;
    import plot_sched_pkg::*;

    logic [1:0]       req;
    logic [X_W-1:0]   req_x0;
    logic [X_W-1:0]   req_x1;
    logic [Y_W-1:0]   req_y0;
    logic [Y_W-1:0]   req_y1;
    logic [COL_W-1:0] req_col0;
    logic [COL_W-1:0] req_col1;
    logic             clear_req;
    logic [COL_W-1:0] clear_colour;
    logic [1:0]       ack;
    logic             clear_ack;
    logic             busy;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] colour;
    logic             plot;

    modport master (
        output req, req_x0, req_x1, req_y0, req_y1, req_col0, req_col1,
        output clear_req, clear_colour,
        input  ack, clear_ack, busy, x, y, colour, plot
    );

    modport slave (
        input  req, req_x0, req_x1, req_y0, req_y1, req_col0, req_col1,
        input  clear_req, clear_colour,
        output ack, clear_ack, busy, x, y, colour, plot
    );

endinterface

`default_nettype wire

// File: rtl/plot_raster_counter.sv
// ---- plot_raster_counter : row-major column/row walker with run-time size, rev 1.0 ----
`default_nettype none

module plot_raster_counter
    import plot_sched_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           start_i,
    input  logic           adv_i,
    input  logic [X_W-1:0] width_i,
    input  logic [Y_W-1:0] height_i,
    output logic [X_W-1:0] col_nxt_o,
    output logic [Y_W-1:0] row_nxt_o,
    output logic           last_o
);

    logic [X_W-1:0] col_q;
    logic [Y_W-1:0] row_q;
    logic           col_end_d;

    // col_q/row_q index the pixel currently on the scheduler outputs
    always_comb begin
        col_end_d = (col_q == width_i - X_W'(1));
        last_o    = col_end_d && (row_q == height_i - Y_W'(1));
        col_nxt_o = col_end_d ? '0 : col_q + X_W'(1);
        row_nxt_o = col_end_d ? row_q + Y_W'(1) : row_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (start_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (adv_i) begin
            col_q <= col_nxt_o;
            row_q <= row_nxt_o;
        end
    end

endmodule

`default_nettype wire

// File: rtl/plot_scheduler.sv
// ---- plot_scheduler : arbitrates square draws and screen clears onto one pixel port, rev 1.0 ----
// The clear engine is compiled in only when PLOT_SCHED_CLEAR_EN is defined.
`default_nettype none

module plot_scheduler
    import plot_sched_pkg::*;
#(
    parameter int SQ_SIZE  = DEF_SQ_SIZE,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic            clk,
    input  logic            reset,
    plot_scheduler_if.slave bus
);

    state_t           state_q;
    logic             owner_q;
    logic             rr_last_q;
    logic [X_W-1:0]   base_x_q;
    logic [Y_W-1:0]   base_y_q;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic [COL_W-1:0] colour_q;
    logic             plot_q;
    logic             busy_q;
    logic [1:0]       ack_q;

    logic             grant_d;
    logic [X_W-1:0]   x_raw_d;
    logic [Y_W-1:0]   y_raw_d;
    logic [X_W-1:0]   gx_d;
    logic [Y_W-1:0]   gy_d;
    logic [COL_W-1:0] gc_d;
    logic             in_arb_d;
    logic             in_job_d;
    logic             sq_go_d;
    logic             start_d;
    logic             adv_d;
    logic [X_W-1:0]   cnt_w_d;
    logic [Y_W-1:0]   cnt_h_d;
    logic [X_W-1:0]   col_nxt;
    logic [Y_W-1:0]   row_nxt;
    logic             px_last;

`ifdef PLOT_SCHED_CLEAR_EN
    logic             clear_go_d;
    logic             clear_ack_q;
`endif

    // DONE arbitrates like IDLE so back-to-back jobs are separated by only the ack cycle
    always_comb begin
        grant_d  = (bus.req == 2'b11) ? ~rr_last_q : bus.req[1];
        x_raw_d  = grant_d ? bus.req_x1 : bus.req_x0;
        y_raw_d  = grant_d ? bus.req_y1 : bus.req_y0;
        gc_d     = grant_d ? bus.req_col1 : bus.req_col0;
        gx_d     = X_W'(clamp_coord(int'(x_raw_d), SCREEN_W - SQ_SIZE));
        gy_d     = Y_W'(clamp_coord(int'(y_raw_d), SCREEN_H - SQ_SIZE));
        in_arb_d = (state_q == IDLE) || (state_q == DONE);
        in_job_d = (state_q == SQUARE) || (state_q == CLEAR);
`ifdef PLOT_SCHED_CLEAR_EN
        clear_go_d = in_arb_d && bus.clear_req;
        sq_go_d    = in_arb_d && (bus.req != 2'b00) && !bus.clear_req;
        start_d    = clear_go_d || sq_go_d;
`else
        sq_go_d    = in_arb_d && (bus.req != 2'b00);
        start_d    = sq_go_d;
`endif
        adv_d    = in_job_d && !px_last;
        cnt_w_d  = (state_q == CLEAR) ? X_W'(SCREEN_W) : X_W'(SQ_SIZE);
        cnt_h_d  = (state_q == CLEAR) ? Y_W'(SCREEN_H) : Y_W'(SQ_SIZE);
    end

    plot_raster_counter u_raster (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start_d),
        .adv_i     (adv_d),
        .width_i   (cnt_w_d),
        .height_i  (cnt_h_d),
        .col_nxt_o (col_nxt),
        .row_nxt_o (row_nxt),
        .last_o    (px_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            base_x_q  <= '0;
            base_y_q  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 2'b00;
`ifdef PLOT_SCHED_CLEAR_EN
            clear_ack_q <= 1'b0;
`endif
        end else begin
            ack_q <= 2'b00;
`ifdef PLOT_SCHED_CLEAR_EN
            clear_ack_q <= 1'b0;
`endif
            if (in_arb_d) begin
`ifdef PLOT_SCHED_CLEAR_EN
                if (clear_go_d) begin
                    state_q  <= CLEAR;
                    base_x_q <= '0;
                    base_y_q <= '0;
                    x_q      <= '0;
                    y_q      <= '0;
                    colour_q <= bus.clear_colour;
                    plot_q   <= 1'b1;
                    busy_q   <= 1'b1;
                end else
`endif
                if (sq_go_d) begin
                    state_q   <= SQUARE;
                    owner_q   <= grant_d;
                    rr_last_q <= grant_d;
                    base_x_q  <= gx_d;
                    base_y_q  <= gy_d;
                    x_q       <= gx_d;
                    y_q       <= gy_d;
                    colour_q  <= gc_d;
                    plot_q    <= 1'b1;
                    busy_q    <= 1'b1;
                end else begin
                    state_q <= IDLE;
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            end else if (px_last) begin
                state_q <= DONE;
                plot_q  <= 1'b0;
                if (state_q == SQUARE) ack_q[owner_q] <= 1'b1;
`ifdef PLOT_SCHED_CLEAR_EN
                else clear_ack_q <= 1'b1;
`endif
            end else begin
                x_q <= base_x_q + col_nxt;
                y_q <= base_y_q + row_nxt;
            end
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.ack    = ack_q;
`ifdef PLOT_SCHED_CLEAR_EN
    assign bus.clear_ack = clear_ack_q;
`else
    assign bus.clear_ack = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_plot_scheduler.sv
// ---- tb_plot_scheduler : scoreboard bench for plot_scheduler, rev 1.0 ----
`default_nettype none

module tb_plot_scheduler;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    plot_scheduler_if bus ();

    plot_scheduler #(
        .SQ_SIZE  (4),
        .SCREEN_W (160),
        .SCREEN_H (120)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit         is_evt;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic [2:0] evt;   // {clear_ack, ack[1:0]}
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   pix_cnt  = 0;
    logic prev_plot = 1'b0;
    int   base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req_v, $time);
        end
    endtask

    task automatic push_square(input int x0, input int y0, input int c, input logic [1:0] a);
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                exp_q.push_back('{1'b0, 8'(x0 + k), 7'(y0 + r), 3'(c), 3'b000});
        exp_q.push_back('{1'b1, 8'd0, 7'd0, 3'd0, {1'b0, a}});
    endtask

    task automatic push_clear(input int npix, input logic [2:0] c, input bit with_evt);
        for (int i = 0; i < npix; i++)
            exp_q.push_back('{1'b0, 8'(i % 160), 7'(i / 160), c, 3'b000});
        if (with_evt) exp_q.push_back('{1'b1, 8'd0, 7'd0, 3'd0, 3'b100});
    endtask

    task automatic wait_evt(input string name, input logic [2:0] want, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if ({bus.clear_ack, bus.ack} == want) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_pix(input string name, input int target, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (pix_cnt >= target) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    // Monitor: every plot or ack/clear_ack cycle consumes one scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        if (bus.plot || bus.ack != 2'b00 || bus.clear_ack) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'({bus.plot, bus.clear_ack, bus.ack}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                if (e.is_evt) begin
                    chk("done_event", 32'({bus.plot, bus.clear_ack, bus.ack}), 32'({1'b0, e.evt}));
                    chk("done_after_last_pixel", 32'(prev_plot), 32'd1);
                end else begin
                    chk("pixel_plot_col_y_x", 32'({bus.plot, bus.colour, bus.y, bus.x}),
                        32'({1'b1, e.c, e.y, e.x}));
                end
            end
        end
        if (bus.plot) pix_cnt++;
        prev_plot = bus.plot;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        bus.req = 2'b00;
        bus.req_x0 = '0; bus.req_x1 = '0;
        bus.req_y0 = '0; bus.req_y1 = '0;
        bus.req_col0 = '0; bus.req_col1 = '0;
        bus.clear_req = 1'b0;
        bus.clear_colour = '0;
        repeat (3) @(negedge clk);
        chk("rst_x", 32'(bus.x), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_colour", 32'(bus.colour), 32'd0);
        chk("rst_plot", 32'(bus.plot), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_clear_ack", 32'(bus.clear_ack), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;

        // Single square; inputs changed after grant must be ignored
        push_square(10, 20, 5, 2'b01);
        bus.req_x0 = 8'd10; bus.req_y0 = 7'd20; bus.req_col0 = 3'd5; bus.req = 2'b01;
        @(negedge clk);
        chk("first_pixel_latency", 32'(bus.plot), 32'd1);
        bus.req_x0 = 8'd99; bus.req_y0 = 7'd99; bus.req_col0 = 3'd1;
        wait_evt("ack_req0", 3'b001, 40);
        bus.req = 2'b00;
        @(negedge clk);
        chk("busy_falls_after_ack", 32'(bus.busy), 32'd0);
        chk("idle_plot_low", 32'(bus.plot), 32'd0);
        chk("idle_x_hold", 32'(bus.x), 32'd13);
        chk("idle_y_hold", 32'(bus.y), 32'd23);

        // Both requesters after reset: req0 first, one-cycle gap, then req1
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        push_square(30, 40, 2, 2'b01);
        push_square(50, 60, 6, 2'b10);
        bus.req_x0 = 8'd30; bus.req_y0 = 7'd40; bus.req_col0 = 3'd2;
        bus.req_x1 = 8'd50; bus.req_y1 = 7'd60; bus.req_col1 = 3'd6;
        bus.req = 2'b11;
        wait_evt("ack_job0", 3'b001, 40);
        bus.req[0] = 1'b0;
        chk("gap_plot_low", 32'(bus.plot), 32'd0);
        @(negedge clk);
        chk("job1_first_pixel", 32'({bus.plot, bus.y, bus.x}), 32'({1'b1, 7'd60, 8'd50}));
        wait_evt("ack_job1", 3'b010, 40);
        bus.req = 2'b00;

        // Clamped origin, plus a req1 pulse dropped before it could be granted
        push_square(156, 116, 7, 2'b01);
        bus.req_x0 = 8'd158; bus.req_y0 = 7'd119; bus.req_col0 = 3'd7;
        bus.req = 2'b01;
        base = pix_cnt;
        wait_pix("clamp_pix2", base + 2, 20);
        bus.req[1] = 1'b1;
        wait_pix("clamp_pix6", base + 6, 20);
        bus.req[1] = 1'b0;
        wait_evt("ack_clamp", 3'b001, 40);
        bus.req = 2'b00;
        repeat (3) @(negedge clk);
        chk("dropped_req_idle", 32'(bus.busy), 32'd0);

        // Full-screen clear
        bus.clear_colour = 3'd0;
`ifdef PLOT_SCHED_CLEAR_EN
        push_clear(19200, 3'd0, 1'b1);
        bus.clear_req = 1'b1;
        wait_evt("clear_ack", 3'b100, 20000);
        bus.clear_req = 1'b0;
        @(negedge clk);
        chk("clear_busy_falls", 32'(bus.busy), 32'd0);
`else
        bus.clear_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("clear_disabled_busy", 32'(bus.busy), 32'd0);
        end
        chk("clear_disabled_plot", 32'(bus.plot), 32'd0);
        bus.clear_req = 1'b0;
`endif

        // Clear raised mid-square waits; reset mid-clear aborts without clear_ack
        push_square(4, 8, 3, 2'b01);
`ifdef PLOT_SCHED_CLEAR_EN
        push_clear(100, 3'd6, 1'b0);
`endif
        bus.req_x0 = 8'd4; bus.req_y0 = 7'd8; bus.req_col0 = 3'd3;
        bus.req = 2'b01;
        base = pix_cnt;
        wait_pix("square_pix5", base + 5, 20);
        bus.clear_colour = 3'd6;
        bus.clear_req = 1'b1;
        wait_evt("ack_before_clear", 3'b001, 40);
        bus.req = 2'b00;
`ifdef PLOT_SCHED_CLEAR_EN
        base = pix_cnt;
        wait_pix("clear_pix100", base + 100, 200);
        reset = 1'b0;
        bus.clear_req = 1'b0;
        @(negedge clk);
        chk("abort_plot", 32'(bus.plot), 32'd0);
        chk("abort_clear_ack", 32'(bus.clear_ack), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;
`else
        @(negedge clk);
        chk("clear_ignored_after_square", 32'(bus.busy), 32'd0);
        bus.clear_req = 1'b0;
`endif
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
